button_conditioner: RTL



---
 rtl/button_conditioner.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Conditions raw board buttons and digit switches for interfaceController.
//   Each button is synchronized, debounced and edge-detected; navigation
//   buttons auto-repeat while held. One command pulse per cycle at most
//   (write > left > right > up > down). The switch group is debounced as a
//   unit and never changes on the edge that raises writeBit.
//
// Ports
//   CLK, RST                       clock (posedge), async active-low reset
//   btn{Up,Down,Left,Right,Write}Raw  raw asynchronous button levels
//   swRaw[3:0]                     raw asynchronous digit switches
//   {up,down,left,right}Button     one-cycle navigation pulses
//   writeBit                       one-cycle write pulse
//   userNum[3:0]                   debounced digit value
// ---------------------------------------------------------------------------

// Per-button lane: sync, polarity fix, debounce, press/repeat event.
module btn_cond_lane #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_event
);
    localparam int   CW     = $clog2(DEBOUNCE_CYCLES);
    localparam int   HMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   HW     = $clog2(HMAX + 1);
    localparam logic REL    = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam bit   RPT_ON = REPEAT_EN && (REPEAT_DELAY != 0);

    logic          r_sync1, r_sync2;
    logic          r_stable, r_prev;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hold;
    logic          r_phase;   // 0: waiting initial delay, 1: periodic repeats
    logic          w_lvl, w_mis, w_press, w_rep;
    logic [HW-1:0] w_tgt;

    // Synchronizer resets to the released level so a held button after
    // reset looks like a fresh press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= REL;
            r_sync2 <= REL;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lvl = r_sync2 ^ REL;   // 1 = pressed
    assign w_mis = (w_lvl != r_stable);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b0;
            r_prev   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_prev <= r_stable;
            if (!w_mis) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= w_lvl;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_stable & ~r_prev;

    // Hold counter runs while stable; it reaches REPEAT_DELAY exactly
    // REPEAT_DELAY edges after the press pulse, then restarts at 1 so each
    // following event is REPEAT_PERIOD edges apart.
    assign w_tgt = r_phase ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY);
    assign w_rep = RPT_ON && r_stable && (r_hold == w_tgt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold  <= '0;
            r_phase <= 1'b0;
        end else if (!r_stable || !RPT_ON) begin
            r_hold  <= '0;
            r_phase <= 1'b0;
        end else if (w_rep) begin
            r_hold  <= HW'(1);
            r_phase <= 1'b1;
        end else begin
            r_hold <= r_hold + 1'b1;
        end
    end

    assign o_event = w_press | w_rep;
endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btnUpRaw,
    input  logic       btnDownRaw,
    input  logic       btnLeftRaw,
    input  logic       btnRightRaw,
    input  logic       btnWriteRaw,
    input  logic [3:0] swRaw,
    output logic       upButton,
    output logic       downButton,
    output logic       leftButton,
    output logic       rightButton,
    output logic       writeBit,
    output logic [3:0] userNum
);
    localparam int NB = 5;
    localparam int UP = 0, DN = 1, LT = 2, RT = 3, WR = 4;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [NB-1:0] w_raw, w_ev, w_nx, r_out;

    assign w_raw = {btnWriteRaw, btnRightRaw, btnLeftRaw, btnDownRaw, btnUpRaw};

    for (genvar i = 0; i < NB; i++) begin : g_lane
        btn_cond_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
            .REPEAT_EN      (i != WR)
        ) u_lane (
            .i_clk  (CLK),
            .i_rst_n(RST),
            .i_raw  (w_raw[i]),
            .o_event(w_ev[i])
        );
    end

    // Fixed priority; losers are dropped.
    always_comb begin
        w_nx = '0;
        if      (w_ev[WR]) w_nx[WR] = 1'b1;
        else if (w_ev[LT]) w_nx[LT] = 1'b1;
        else if (w_ev[RT]) w_nx[RT] = 1'b1;
        else if (w_ev[UP]) w_nx[UP] = 1'b1;
        else if (w_ev[DN]) w_nx[DN] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_out <= '0;
        else      r_out <= w_nx;
    end

    assign upButton    = r_out[UP];
    assign downButton  = r_out[DN];
    assign leftButton  = r_out[LT];
    assign rightButton = r_out[RT];
    assign writeBit    = r_out[WR];

    // Digit switches: any bit change restarts the count. A due update that
    // collides with the edge raising writeBit is held off one cycle (the
    // counter stays at its terminal value).
    logic [3:0]    r_sw1, r_sw2, r_sw_last, r_num;
    logic [CW-1:0] r_sw_cnt;
    logic          w_sw_chg, w_sw_mis;

    assign w_sw_chg = (r_sw2 != r_sw_last);
    assign w_sw_mis = (r_sw2 != r_num);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sw1     <= '0;
            r_sw2     <= '0;
            r_sw_last <= '0;
            r_num     <= '0;
            r_sw_cnt  <= '0;
        end else begin
            r_sw1     <= swRaw;
            r_sw2     <= r_sw1;
            r_sw_last <= r_sw2;
            if (w_sw_chg || !w_sw_mis) begin
                r_sw_cnt <= '0;
            end else if (r_sw_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                if (!w_nx[WR]) begin
                    r_num    <= r_sw2;
                    r_sw_cnt <= '0;
                end
            end else begin
                r_sw_cnt <= r_sw_cnt + 1'b1;
            end
        end
    end

    assign userNum = r_num;
endmodule
